// File: rtl/sub8_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sub8_serial
//  Description : Bit-serial 8-bit subtractor. Computes A - B - Bi one bit per
//                clock, LSB first, and reports difference, borrow-out,
//                signed overflow and zero flags with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sub8_serial (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Bi,
   output logic [7:0] Y,
   output logic       Bo,
   output logic       V,
   output logic       Z,
   output logic       busy,
   output logic       done
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] c_LAST_BIT = 3'd7;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [6:0] r_res;     // bits 0..6 of the difference; bit 7 joins on the final edge
   logic       r_br;

   logic       w_load;
   logic       w_step;
   logic       w_last;
   logic       w_d;
   logic       w_br_nxt;
   logic [7:0] w_result;

   // One full-subtractor slice acting on the current LSBs
   assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_result = {w_d, r_res};
   assign busy     = (r_state == S_RUN);

   // Next-state and control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (r_cnt == c_LAST_BIT) begin
               w_last      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Operand capture, serial shifting and bit counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_a   <= 8'h00;
         r_b   <= 8'h00;
         r_br  <= 1'b0;
         r_res <= 7'h00;
         r_cnt <= 3'd0;
      end else if (w_load) begin
         r_a   <= A;
         r_b   <= B;
         r_br  <= Bi;
         r_res <= 7'h00;
         r_cnt <= 3'd0;
      end else if (w_step) begin
         r_a   <= {1'b0, r_a[7:1]};
         r_b   <= {1'b0, r_b[7:1]};
         r_br  <= w_br_nxt;
         r_res <= {w_d, r_res[6:1]};
         r_cnt <= r_cnt + 3'd1;
      end
   end

   // Visible results update only on the edge that processes bit 7
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         Y    <= 8'h00;
         Bo   <= 1'b0;
         V    <= 1'b0;
         Z    <= 1'b1;
         done <= 1'b0;
      end else begin
         done <= w_last;
         if (w_last) begin
            Y  <= w_result;
            Bo <= w_br_nxt;
            V  <= r_br ^ w_br_nxt;
            Z  <= (w_result == 8'h00);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sub8_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub8_serial
//  Description : Self-checking bench for sub8_serial: directed vector table,
//                randomized operations against an arithmetic reference,
//                back-to-back streaming and mid-operation reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sub8_serial;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       Bi;
   logic [7:0] Y;
   logic       Bo;
   logic       V;
   logic       Z;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   sub8_serial dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .A       (A),
      .B       (B),
      .Bi      (Bi),
      .Y       (Y),
      .Bo      (Bo),
      .V       (V),
      .Z       (Z),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bi;
      logic [7:0] y;
      logic       bo;
      logic       v;
      logic       z;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] y, output logic bo, output logic v, output logic z);
      int ua, ub, sa, sb, diff, sdiff;
      ua    = int'(a);
      ub    = int'(b);
      sa    = a[7] ? ua - 256 : ua;
      sb    = b[7] ? ub - 256 : ub;
      diff  = ua - ub - int'(bi);
      sdiff = sa - sb - int'(bi);
      y     = 8'(diff & 255);
      bo    = (ua < ub + int'(bi));
      v     = (sdiff < -128) || (sdiff > 127);
      z     = (y == 8'h00);
   endtask

   // Call from #1 after a rising edge with the DUT idle
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ey, input logic ebo, input logic ev, input logic ez);
      int   lat;
      logic hold_ok;
      logic [7:0] hy;
      logic hbo, hv, hz;
      A = a; B = b; Bi = bi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", busy, 1);
      hy = Y; hbo = Bo; hv = V; hz = Z;
      lat = 0;
      hold_ok = 1'b1;
      while (!done && lat < 20) begin
         A  = 8'($urandom);
         B  = 8'($urandom);
         Bi = 1'($urandom);
         start = (lat < 7) ? 1'($urandom) : 1'b0;
         @(posedge clk); #1;
         lat++;
         if (!done && (Y !== hy || Bo !== hbo || V !== hv || Z !== hz)) hold_ok = 1'b0;
      end
      check("latency", lat, 8);
      check("hold_during_run", hold_ok, 1);
      check("Y", Y, ey);
      check("Bo", Bo, ebo);
      check("V", V, ev);
      check("Z", Z, ez);
      check("busy_in_done", busy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   logic [7:0] sa_q[40];
   logic [7:0] sb_q[40];
   logic       sbi_q[40];

   initial begin
      logic [7:0] ey;
      logic ebo, ev, ez, exp_done, seen_done;
      int guard;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

      reset_n = 1'b0; start = 1'b1; A = 8'hAA; B = 8'h55; Bi = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_Y", Y, 8'h00);
      check("rst_Bo", Bo, 0);
      check("rst_V", V, 0);
      check("rst_Z", Z, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset_n = 1'b1;

      // Directed table; first entry is accepted at the first edge out of reset
      for (int i = 0; i < 10; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].y, vecs[i].bo, vecs[i].v, vecs[i].z);

      // Randomized operations against the arithmetic reference
      for (int i = 0; i < 1500; i++) begin
         logic [7:0] ra, rb;
         logic rbi;
         ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
         model(ra, rb, rbi, ey, ebo, ev, ez);
         run_op(ra, rb, rbi, ey, ebo, ev, ez);
      end

      // start held high, operands changing every cycle: accept every 9 clocks
      start = 1'b1;
      for (int k = 0; k < 40; k++) begin
         sa_q[k] = 8'($urandom); sb_q[k] = 8'($urandom); sbi_q[k] = 1'($urandom);
         A = sa_q[k]; B = sb_q[k]; Bi = sbi_q[k];
         @(posedge clk); #1;
         exp_done = (k >= 8) && ((k % 9) == 8);
         check("stream_done", done, exp_done);
         check("stream_busy", busy, !exp_done);
         if (exp_done) begin
            model(sa_q[k-8], sb_q[k-8], sbi_q[k-8], ey, ebo, ev, ez);
            check("stream_Y", Y, ey);
            check("stream_Bo", Bo, ebo);
            check("stream_V", V, ev);
            check("stream_Z", Z, ez);
         end
      end
      start = 1'b0;
      guard = 0;
      while (busy && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("stream_drain", busy, 0);
      @(posedge clk); #1;

      // Establish non-reset outputs, then abort an operation at cnt=4
      run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      A = 8'h5A; B = 8'h33; Bi = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("abort_Y", Y, 8'h00);
      check("abort_Bo", Bo, 0);
      check("abort_V", V, 0);
      check("abort_Z", Z, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      seen_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);
      run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
